ib_bit_reader: RTL and testbench
================================

Name: ib_bit_reader

Overview:
- Read-side counterpart of the input-buffer bit packer.
- Fetches 32-bit words from the eight input-buffer RAM banks, addresses 0..NUM_WORDS-1.
- Serialises each word back to one bit per lane per beat on eight lanes, with valid/ready flow control toward the PE array.
- Word buffer plus one-word prefetch register give a gapless stream when the consumer is always ready.

Parameters:
NUM_WORDS, 29, words per bank to read (addresses 0..NUM_WORDS-1)
ADDR_W, 5, RAM address width
WORD_W, 32, RAM word width = bits per word per lane
RD_LAT, 1, RAM read latency in cycles (ENA/ADDR edge to valid DOUT)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse; begins a read pass when idle
DOUT_0..DOUT_7  in  WORD_W each  RAM bank read data
ADDR  out  ADDR_W  RAM address
ENA  out  1  RAM enable, high only on a read-issue cycle
WEA  out  1  RAM write enable, constant 0
Bout_0..Bout_7  out  1 each  serial bit per lane
bout_valid  out  1  Bout_* valid this cycle
bout_ready  in  1  consumer accepts beat when valid&ready
busy  out  1  pass in progress
done  out  1  sticky pass-complete flag

Behaviour:
- Reset (rst high at clk edge): ADDR=0, ENA=0, WEA=0, Bout_*=0, bout_valid=0, busy=0, done=0. All internal state cleared: issue address, read-pending pipe, buffers, bit counter, word counter.
- rst mid-pass aborts the pass. No further ENA until the next start.
- States:
  - IDLE -> RUN on start: busy=1, done cleared.
  - RUN -> DONE when the final beat of word NUM_WORDS-1 is accepted.
  - DONE -> RUN on the next start.
  - start while busy is ignored.
- Read issue is registered:
  - Edge sampling start drives ENA=1, ADDR=0 in the next cycle.
  - Read data is captured RD_LAT cycles after the ENA cycle.
  - At most one read is outstanding.
- Further reads (address n+1) issue only when all hold: issue address < NUM_WORDS, prefetch register empty, no read pending.
- Captured data goes to the shift buffer if it is empty, otherwise to the prefetch register.
- Bit order: MSB first. Bout_k = shift_k[WORD_W-1]. On each accepted beat all eight shift registers shift left by 1 and the bit counter increments.
- After beat WORD_W-1 of a word is accepted:
  - If prefetch is full: load it into the shift buffer on the same edge, bout_valid stays 1 (no bubble).
  - Otherwise bout_valid drops until the next capture.
- bout_valid=1 whenever the shift buffer holds unconsumed bits. Bout_* and bout_valid are held stable while valid & !ready.
- Latency (RD_LAT=1): first bout_valid in the 3rd cycle after the start-sampling edge.
- Throughput with ready=1: NUM_WORDS*WORD_W contiguous beats (928 at defaults).
- Completion: on the edge accepting the last beat, busy<=0, done<=1, bout_valid<=0. done stays high until start or rst.
- ADDR holds its last issued value between reads. ENA is never asserted in IDLE or DONE.
- Simultaneous events:
  - Capture and last-beat on the same edge: the capture goes to the shift buffer if the shift buffer empties on that edge and prefetch is empty, else to prefetch.
  - rst dominates start.

Optional Feature:
- IB_RD_LSB_FIRST_EN defined: bit 0 of each word is emitted first (Bout_k = shift_k[0], shift right on accepted beat).
- Not defined: MSB first as above, matching the packer's shift-in order so the first bit written is the first bit read.

Test Plan:
- Model RAM bank k address a holds {k[2:0], a[4:0], 24'hA5C3_F0 ^ a}. Pulse start, ready=1 -> ENA/ADDR=0 one cycle after start; bout_valid from 3rd cycle. 928 contiguous beats; lane k bitstream equals words 0..28 MSB-first; done=1 and busy=0 the cycle after beat 928; ENA asserted exactly 29 times.
- ready toggled 1-0-0-1 repeating -> same 928-bit sequence per lane, Bout_* stable during every valid&!ready cycle, never more than one read outstanding, no prefetch overwrite.
- start re-pulsed at beat 100 -> ignored, stream unchanged. start after done -> done clears next cycle, pass repeats from ADDR=0.
- rst at beat 300 -> next cycle all outputs 0, no ENA for 20 idle cycles. Fresh start -> full correct pass from word 0.
- ready=0 for 50 cycles from start -> exactly 2 reads issued (shift plus prefetch), then ENA idle until ready resumes.
- With IB_RD_LSB_FIRST_EN: word 32'h0000_0001 on lane 0 -> first Bout_0 beat =1, next 31 beats =0.

Source files
------------

// File: rtl/ib_bit_reader_if.sv
// ib_bit_reader_if
//   Bus bundle between the input-buffer bit reader, the eight input-buffer
//   RAM banks and the PE-array consumer.
//   Signals:
//     start          one-cycle pulse that begins a read pass
//     DOUT_0..7      RAM bank read data (WORD_W each)
//     ADDR, ENA, WEA RAM address, enable, write enable (WEA is always 0)
//     Bout_0..7      one serial bit per lane
//     bout_valid     Bout_* valid this cycle
//     bout_ready     consumer accepts the beat when valid & ready
//     busy, done     pass in progress / sticky pass-complete flag
//   Modports: master = the reader, slave = RAMs plus consumer side.
`timescale 1ns/1ps
interface ib_bit_reader_if #(
  parameter int ADDR_W = 5,
  parameter int WORD_W = 32
);
  logic              start;
  logic [WORD_W-1:0] DOUT_0, DOUT_1, DOUT_2, DOUT_3;
  logic [WORD_W-1:0] DOUT_4, DOUT_5, DOUT_6, DOUT_7;
  logic [ADDR_W-1:0] ADDR;
  logic              ENA;
  logic              WEA;
  logic              Bout_0, Bout_1, Bout_2, Bout_3;
  logic              Bout_4, Bout_5, Bout_6, Bout_7;
  logic              bout_valid;
  logic              bout_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, DOUT_0, DOUT_1, DOUT_2, DOUT_3, DOUT_4, DOUT_5, DOUT_6, DOUT_7,
    input  bout_ready,
    output ADDR, ENA, WEA,
    output Bout_0, Bout_1, Bout_2, Bout_3, Bout_4, Bout_5, Bout_6, Bout_7,
    output bout_valid, busy, done
  );

  modport slave (
    output start, DOUT_0, DOUT_1, DOUT_2, DOUT_3, DOUT_4, DOUT_5, DOUT_6, DOUT_7,
    output bout_ready,
    input  ADDR, ENA, WEA,
    input  Bout_0, Bout_1, Bout_2, Bout_3, Bout_4, Bout_5, Bout_6, Bout_7,
    input  bout_valid, busy, done
  );
endinterface

// File: rtl/ib_bit_reader.sv
// ib_bit_reader
//   Reads words 0..NUM_WORDS-1 from the eight input-buffer RAM banks and
//   serialises them as one bit per lane per beat on eight lanes, with
//   valid/ready flow control toward the PE array. A per-lane shift buffer
//   plus a one-word prefetch register keep the stream gapless while the
//   consumer is always ready. At most one RAM read is in flight.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset (aborts a pass, clears all state)
//     bus  ib_bit_reader_if.master (start, RAM port, serial lanes, status)
//   Option macro IB_RD_LSB_FIRST_EN: when defined, bit 0 of every word is
//   emitted first; otherwise MSB first, matching the packer's shift-in order.
`timescale 1ns/1ps
module ib_bit_reader #(
  parameter int NUM_WORDS = 29,
  parameter int ADDR_W    = 5,
  parameter int WORD_W    = 32,
  parameter int RD_LAT    = 1
) (
  input  logic             clk,
  input  logic             rst,
  ib_bit_reader_if.master  bus
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int BIT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] N_WORDS   = CNT_W'(NUM_WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NUM_WORDS - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(WORD_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state, state_nx;
  logic              issue;
  logic              ena_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [CNT_W-1:0]  issue_addr;
  logic [RD_LAT-1:0] rd_vld_p1;
  logic [WORD_W-1:0] dout [8];
  logic [WORD_W-1:0] sh   [8];
  logic [WORD_W-1:0] pf   [8];
  logic              sh_full, pf_full;
  logic [BIT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  word_cnt;
  logic              start_go, accept, word_end, last_beat;
  logic              pending, capture, cap_to_sh, cap_to_pf;

  function automatic logic [WORD_W-1:0] shift_word(input logic [WORD_W-1:0] w);
`ifdef IB_RD_LSB_FIRST_EN
    return w >> 1;
`else
    return w << 1;
`endif
  endfunction

  function automatic logic head_bit(input logic [WORD_W-1:0] w);
`ifdef IB_RD_LSB_FIRST_EN
    return w[0];
`else
    return w[WORD_W-1];
`endif
  endfunction

  assign dout[0] = bus.DOUT_0;
  assign dout[1] = bus.DOUT_1;
  assign dout[2] = bus.DOUT_2;
  assign dout[3] = bus.DOUT_3;
  assign dout[4] = bus.DOUT_4;
  assign dout[5] = bus.DOUT_5;
  assign dout[6] = bus.DOUT_6;
  assign dout[7] = bus.DOUT_7;

  assign start_go  = (state != S_RUN) && bus.start;
  assign accept    = sh_full && bus.bout_ready;
  assign word_end  = accept && (bit_cnt == LAST_BIT);
  assign last_beat = word_end && (word_cnt == LAST_WORD);
  // A read counts as pending from its ENA cycle through its capture cycle.
  assign pending   = ena_p0 || (|rd_vld_p1);
  assign capture   = rd_vld_p1[RD_LAT-1];
  // Captured word goes straight to the shift buffer when it is (or is about
  // to become) empty with nothing waiting in prefetch.
  assign cap_to_sh = capture && (!sh_full || (word_end && !pf_full));
  assign cap_to_pf = capture && !cap_to_sh;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_nx = S_RUN;
          issue    = 1'b1;
        end
      end
      S_RUN: begin
        issue = (issue_addr < N_WORDS) && !pf_full && !pending;
        if (last_beat) state_nx = S_DONE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ena_p0     <= 1'b0;
      addr_p0    <= '0;
      issue_addr <= '0;
      rd_vld_p1  <= '0;
      sh_full    <= 1'b0;
      pf_full    <= 1'b0;
      bit_cnt    <= '0;
      word_cnt   <= '0;
      for (int k = 0; k < 8; k++) begin
        sh[k] <= '0;
        pf[k] <= '0;
      end
    end else begin
      // Issue stage: registered ENA/ADDR toward the RAM banks
      ena_p0    <= issue;
      rd_vld_p1 <= (rd_vld_p1 << 1) | RD_LAT'(ena_p0);
      if (issue) begin
        if (start_go) begin
          addr_p0    <= '0;
          issue_addr <= CNT_W'(1);
        end else begin
          addr_p0    <= issue_addr[ADDR_W-1:0];
          issue_addr <= issue_addr + CNT_W'(1);
        end
      end
      if (start_go) begin
        bit_cnt  <= '0;
        word_cnt <= '0;
      end

      // Serialise stage: shift buffer, prefetch and beat counters
      if (accept) begin
        for (int k = 0; k < 8; k++) sh[k] <= shift_word(sh[k]);
        bit_cnt <= word_end ? '0 : bit_cnt + BIT_W'(1);
      end
      if (word_end) begin
        word_cnt <= word_cnt + CNT_W'(1);
        if (pf_full) begin
          sh      <= pf;
          pf_full <= 1'b0;
        end else begin
          sh_full <= 1'b0;
        end
      end
      if (cap_to_sh) begin
        sh      <= dout;
        sh_full <= 1'b1;
      end
      if (cap_to_pf) begin
        pf      <= dout;
        pf_full <= 1'b1;
      end
      if (last_beat) sh_full <= 1'b0;
    end
  end

  assign bus.ADDR       = addr_p0;
  assign bus.ENA        = ena_p0;
  assign bus.WEA        = 1'b0;
  assign bus.bout_valid = sh_full;
  assign bus.busy       = (state == S_RUN);
  assign bus.done       = (state == S_DONE);
  assign bus.Bout_0     = head_bit(sh[0]);
  assign bus.Bout_1     = head_bit(sh[1]);
  assign bus.Bout_2     = head_bit(sh[2]);
  assign bus.Bout_3     = head_bit(sh[3]);
  assign bus.Bout_4     = head_bit(sh[4]);
  assign bus.Bout_5     = head_bit(sh[5]);
  assign bus.Bout_6     = head_bit(sh[6]);
  assign bus.Bout_7     = head_bit(sh[7]);

endmodule

// File: tb/tb_ib_bit_reader.sv
// tb_ib_bit_reader
//   Scoreboard bench for ib_bit_reader. A RAM model returns
//   {k[2:0], a[4:0], 24'hA5C3F0 ^ a} for bank k, address a. Each start
//   pushes the full expected per-lane bitstream into a queue; a monitor pops
//   and compares on every accepted beat, and also watches ENA spacing,
//   stall stability and the done/busy state after the final beat.
`timescale 1ns/1ps
module tb_ib_bit_reader;
  localparam int NUM_WORDS = 29;
  localparam int ADDR_W    = 5;
  localparam int WORD_W    = 32;
  localparam int RD_LAT    = 1;

  logic clk = 1'b0;
  logic rst;

  ib_bit_reader_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus();

  ib_bit_reader #(
    .NUM_WORDS(NUM_WORDS), .ADDR_W(ADDR_W), .WORD_W(WORD_W), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];
  int beats_seen = 0;
  int ena_cnt    = 0;
  int cyc        = 0;
  int mode       = 0;

  logic [7:0] bout_vec;
  assign bout_vec = {bus.Bout_7, bus.Bout_6, bus.Bout_5, bus.Bout_4,
                     bus.Bout_3, bus.Bout_2, bus.Bout_1, bus.Bout_0};

  function automatic logic [31:0] ram_word(input int k, input int a);
    logic [4:0] a5;
    a5 = 5'(a);
    return {3'(k), a5, 24'hA5C3F0 ^ {19'd0, a5}};
  endfunction

  // Bit emitted on beat b of a word
  function automatic logic exp_bit(input logic [31:0] w, input int b);
`ifdef IB_RD_LSB_FIRST_EN
    return w[b];
`else
    return w[31-b];
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pass();
    logic [7:0] v;
    for (int w = 0; w < NUM_WORDS; w++)
      for (int b = 0; b < WORD_W; b++) begin
        for (int k = 0; k < 8; k++) v[k] = exp_bit(ram_word(k, w), b);
        exp_q.push_back(v);
      end
  endtask

  // RAM banks, one-cycle read latency
  always @(posedge clk) begin
    if (bus.ENA) begin
      bus.DOUT_0 <= ram_word(0, int'(bus.ADDR));
      bus.DOUT_1 <= ram_word(1, int'(bus.ADDR));
      bus.DOUT_2 <= ram_word(2, int'(bus.ADDR));
      bus.DOUT_3 <= ram_word(3, int'(bus.ADDR));
      bus.DOUT_4 <= ram_word(4, int'(bus.ADDR));
      bus.DOUT_5 <= ram_word(5, int'(bus.ADDR));
      bus.DOUT_6 <= ram_word(6, int'(bus.ADDR));
      bus.DOUT_7 <= ram_word(7, int'(bus.ADDR));
    end
  end

  // Consumer ready driver: 0 always ready, 1 pattern 1-0-0-1, 2 random, 3 stalled
  initial begin
    int ph;
    ph = 0;
    bus.bout_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0: bus.bout_ready = 1'b1;
        1: begin
          bus.bout_ready = (ph == 0) || (ph == 3);
          ph = (ph + 1) % 4;
        end
        2: bus.bout_ready = 1'($urandom_range(0, 1));
        default: bus.bout_ready = 1'b0;
      endcase
    end
  end

  // Monitor / scoreboard
  initial begin
    logic [7:0] prev_bout;
    logic [7:0] e;
    bit prev_stall, want_done, have_ena;
    int last_ena;
    prev_bout = '0; prev_stall = 0; want_done = 0; have_ena = 0; last_ena = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (want_done) begin
        check("done_after_last", 64'({bus.done, bus.busy, bus.bout_valid}), 64'(3'b100));
        want_done = 0;
      end
      if (prev_stall)
        check("stall_hold", 64'({bus.bout_valid, bout_vec}), 64'({1'b1, prev_bout}));
      if (bus.ENA) begin
        ena_cnt++;
        if (have_ena) check("read_spacing", 64'((cyc - last_ena) >= RD_LAT + 1), 64'(1));
        have_ena = 1;
        last_ena = cyc;
      end
      if (!rst && bus.bout_valid && bus.bout_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL beat_unexpected: got beat %0h expected no beat", bout_vec);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("beat%0d", beats_seen), 64'(bout_vec), 64'(e));
          beats_seen++;
          if (exp_q.size() == 0) want_done = 1;
        end
      end
      prev_stall = !rst && bus.bout_valid && !bus.bout_ready;
      prev_bout  = bout_vec;
    end
  end

  // Pulse start from idle/done and check the first three cycles
  task automatic start_pass(output int base);
    base = ena_cnt;
    push_pass();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("c1_ena_addr", 64'({bus.ENA, bus.ADDR}), 64'({1'b1, 5'd0}));
    check("c1_busy_done", 64'({bus.busy, bus.done}), 64'(2'b10));
    check("c1_valid", 64'(bus.bout_valid), 64'(0));
    tick();
    check("c2_valid", 64'(bus.bout_valid), 64'(0));
    tick();
    check("c3_valid", 64'(bus.bout_valid), 64'(1));
  endtask

  task automatic wait_done(input int base, input string tag);
    int n;
    n = 0;
    while (!(bus.done && exp_q.size() == 0) && n < 8000) begin
      tick();
      n++;
    end
    check({tag, "_finished"}, 64'(bus.done && exp_q.size() == 0), 64'(1));
    repeat (5) tick();
    check({tag, "_reads"}, 64'(ena_cnt - base), 64'(NUM_WORDS));
    check({tag, "_idle_status"}, 64'({bus.busy, bus.done, bus.bout_valid}), 64'(3'b010));
  endtask

  task automatic wait_beats(input int target, input string tag);
    int n;
    n = 0;
    while (beats_seen < target && n < 4000) begin
      tick();
      n++;
    end
    check(tag, 64'(beats_seen >= target), 64'(1));
  endtask

  initial begin
    int base, b0;
    bus.start = 1'b0;
    rst = 1'b1;
    mode = 0;
    repeat (3) tick();
    check("reset_outputs",
          64'({bus.ADDR, bus.ENA, bus.WEA, bout_vec, bus.bout_valid, bus.busy, bus.done}), 64'(0));
    rst = 1'b0;
    repeat (2) tick();

    // Pass A: always ready, start re-pulsed at beat 100
    b0 = beats_seen;
    start_pass(base);
    wait_beats(b0 + 100, "passA_beat100");
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("restart_ignored", 64'({bus.busy, bus.done}), 64'(2'b10));
    wait_done(base, "passA");

    // Pass B: started from DONE, ready 1-0-0-1
    mode = 1;
    start_pass(base);
    wait_done(base, "passB");

    // Pass C: reset at beat 300
    mode = 0;
    repeat (2) tick();
    b0 = beats_seen;
    start_pass(base);
    wait_beats(b0 + 300, "passC_beat300");
    rst = 1'b1;
    tick();
    check("rst_outputs",
          64'({bus.ADDR, bus.ENA, bus.WEA, bout_vec, bus.bout_valid, bus.busy, bus.done}), 64'(0));
    rst = 1'b0;
    exp_q.delete();
    base = ena_cnt;
    repeat (20) tick();
    check("no_ena_after_rst", 64'(ena_cnt - base), 64'(0));
    check("idle_after_rst", 64'({bus.busy, bus.done, bus.bout_valid}), 64'(0));

    // Pass D: fresh start, random ready
    mode = 2;
    start_pass(base);
    wait_done(base, "passD");

    // Pass E: consumer stalled for ~50 cycles, then random ready
    mode = 3;
    repeat (2) tick();
    start_pass(base);
    repeat (47) tick();
    check("stall_reads", 64'(ena_cnt - base), 64'(2));
    check("stall_valid", 64'(bus.bout_valid), 64'(1));
    mode = 2;
    wait_done(base, "passE");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
